sobel_window_ctrl: RTL and testbench



---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_window_ctrl_raster_counter.sv | 62 ++++++
 rtl/sobel_window_ctrl.sv | 105 ++++++++++
 tb/tb_sobel_window_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel window loader controller.
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_STREAM,
      ST_DONE
   } state_e;

   localparam int IMG_WIDTH_DEF  = 640;
   localparam int IMG_HEIGHT_DEF = 480;
   localparam int DATA_W_DEF     = 8;

   // Bits needed to hold max(w, h) - 1.
   function automatic int cnt_width(input int w, input int h);
      int m;
      int n;
      m = ((w > h) ? w : h) - 1;
      n = 1;
      while ((1 << n) <= m) n++;
      return n;
   endfunction

endpackage

// File: rtl/sobel_window_ctrl_raster_counter.sv
// Raster position tracker: column/row counters with wrap plus position flags
// for the current (not yet accepted) pixel.
module raster_counter
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int CNT_W      = cnt_width(IMG_WIDTH, IMG_HEIGHT)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             adv_i,
   output logic [CNT_W-1:0] row_o,
   output logic [CNT_W-1:0] col_o,
   output logic             last_o,
   output logic             prime_o,
   output logic             win_o
);

   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic             col_last;
   logic             row_last;

   assign col_last = (col_q == CNT_W'(IMG_WIDTH - 1));
   assign row_last = (row_q == CNT_W'(IMG_HEIGHT - 1));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (adv_i) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign row_o   = row_q;
   assign col_o   = col_q;
   assign last_o  = col_last && row_last;
   assign prime_o = (row_q == CNT_W'(2)) && (col_q == CNT_W'(1));
   // Taps straddle two rows at columns 0 and 1, so no window there.
   assign win_o   = (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2));

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequencing controller feeding the 3x3 Sobel line-buffer FIFOs from a
// valid/ready raster stream; flags complete windows with their centre.
module sobel_window_ctrl
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int CNT_W      = cnt_width(IMG_WIDTH, IMG_HEIGHT)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Start,
   input  logic              In_Valid,
   input  logic [DATA_W-1:0] In_Data,
   output logic              In_Ready,
   input  logic              Stall,
   output logic              Fifo_Enable,
   output logic [DATA_W-1:0] Fifo_DataIn,
   output logic              Win_Valid,
   output logic [CNT_W-1:0]  Win_Row,
   output logic [CNT_W-1:0]  Win_Col,
   output logic              Busy,
   output logic              Frame_Done
);

   state_e           state_q, state_d;
   logic             ready_d;
   logic             accept;
   logic             clr;
   logic [CNT_W-1:0] row, col;
   logic             at_last, at_prime, at_win;
   logic             win_valid_q, frame_done_q;
   logic [CNT_W-1:0] win_row_q, win_col_q;

   assign accept = In_Valid && ready_d;
   assign clr    = (Start && (state_q == ST_IDLE)) || (state_q == ST_DONE);

   raster_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .CNT_W      (CNT_W)
   ) u_raster (
      .clk_i   (CLK),
      .rst_i   (RST),
      .clr_i   (clr),
      .adv_i   (accept),
      .row_o   (row),
      .col_o   (col),
      .last_o  (at_last),
      .prime_o (at_prime),
      .win_o   (at_win)
   );

   always_comb begin
      state_d = state_q;
      ready_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) state_d = ST_PRIME;
         end
         ST_PRIME: begin
            ready_d = !Stall;
            if (accept && at_prime) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            ready_d = !Stall;
            if (accept && at_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_valid_q  <= accept && at_win;
         frame_done_q <= accept && at_last && (state_q == ST_STREAM);
         // Window centre lags the newest pixel by one row and one column.
         if (accept && at_win) begin
            win_row_q <= row - CNT_W'(1);
            win_col_q <= col - CNT_W'(1);
         end
      end
   end

   assign In_Ready    = ready_d;
   assign Fifo_Enable = accept;
   assign Fifo_DataIn = In_Data;
   assign Win_Valid   = win_valid_q;
   assign Win_Row     = win_row_q;
   assign Win_Col     = win_col_q;
   assign Busy        = (state_q != ST_IDLE);
   assign Frame_Done  = frame_done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 5x4 image.
module tb_sobel_window_ctrl;

   localparam int W   = 5;
   localparam int H   = 4;
   localparam int DW  = 8;
   localparam int CW  = 3;
   localparam int NPX = W * H;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          Start = 1'b0;
   logic          In_Valid = 1'b0;
   logic [DW-1:0] In_Data = '0;
   logic          In_Ready;
   logic          Stall = 1'b0;
   logic          Fifo_Enable;
   logic [DW-1:0] Fifo_DataIn;
   logic          Win_Valid;
   logic [CW-1:0] Win_Row;
   logic [CW-1:0] Win_Col;
   logic          Busy;
   logic          Frame_Done;

   sobel_window_ctrl #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .DATA_W     (DW),
      .CNT_W      (CW)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .Start       (Start),
      .In_Valid    (In_Valid),
      .In_Data     (In_Data),
      .In_Ready    (In_Ready),
      .Stall       (Stall),
      .Fifo_Enable (Fifo_Enable),
      .Fifo_DataIn (Fifo_DataIn),
      .Win_Valid   (Win_Valid),
      .Win_Row     (Win_Row),
      .Win_Col     (Win_Col),
      .Busy        (Busy),
      .Frame_Done  (Frame_Done)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected centres for a 5x4 frame, raster order.
   int exp_r [6] = '{1, 1, 1, 2, 2, 2};
   int exp_c [6] = '{1, 2, 3, 1, 2, 3};

   bit mon_en    = 1'b0;
   int acc_idx   = 0;
   int prev_idx  = -1;
   bit prev_acc  = 1'b0;
   bit prev_fd   = 1'b0;
   bit first_win = 1'b0;
   int fd_cnt    = 0;
   int en_cnt    = 0;
   int wq_r[$];
   int wq_c[$];

   // Observe every cycle mid-period: combinational outputs reflect the
   // current inputs, registered outputs reflect the previous edge.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (Stall) begin
            check_eq("rdy_stall", {31'd0, In_Ready}, 32'd0);
            check_eq("en_stall", {31'd0, Fifo_Enable}, 32'd0);
         end
         if (Fifo_Enable) begin
            check_eq("din_pass", {24'd0, Fifo_DataIn}, {24'd0, In_Data});
            check_eq("din_order", {24'd0, Fifo_DataIn}, acc_idx);
         end
         if (!prev_acc) check_eq("wv_no_accept", {31'd0, Win_Valid}, 32'd0);
         if (prev_acc && (prev_idx == 10 || prev_idx == 11))
            check_eq("wv_row_wrap", {31'd0, Win_Valid}, 32'd0);
         if (Win_Valid) begin
            if (!first_win) begin
               check_eq("first_win_lat", prev_idx, 32'd12);
               first_win = 1'b1;
            end
            wq_r.push_back(int'(Win_Row));
            wq_c.push_back(int'(Win_Col));
         end
         if (Frame_Done) begin
            fd_cnt++;
            check_eq("fd_after_last", {31'd0, prev_acc && prev_idx == NPX - 1}, 32'd1);
            check_eq("fd_with_wv", {31'd0, Win_Valid}, 32'd1);
         end
         if (prev_fd) check_eq("busy_after_fd", {31'd0, Busy}, 32'd0);
         prev_acc = Fifo_Enable;
         if (Fifo_Enable) begin
            en_cnt++;
            prev_idx = acc_idx;
            acc_idx++;
         end
         prev_fd = Frame_Done;
      end
   end

   task automatic do_start();
      @(posedge CLK); #1;
      Start = 1'b1; In_Valid = 1'b0; Stall = 1'b0; RST = 1'b0;
      acc_idx = 0; prev_idx = -1; first_win = 1'b0;
      fd_cnt = 0; en_cnt = 0;
      wq_r.delete(); wq_c.delete();
   endtask

   task automatic run_frame(input bit bubbles, input int stall_px, input int start_px,
                            input int rst_px);
      int p = 0;
      int guard = 0;
      int stall_left = 0;
      bit stalled = 1'b0;
      bit started = 1'b0;
      while (p < NPX && guard < 400) begin
         guard++;
         @(posedge CLK); #1;
         Start = 1'b0;
         if (p == rst_px) begin
            RST = 1'b1; In_Valid = 1'b0; Stall = 1'b0;
            @(negedge CLK);
            return;
         end
         if (p == stall_px && !stalled) begin
            stall_left = 3;
            stalled = 1'b1;
         end
         Stall = (stall_left > 0);
         if (stall_left > 0) stall_left--;
         In_Valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (Stall) In_Valid = 1'b1;
         In_Data = DW'(p);
         if (p == start_px && !started) begin
            Start = 1'b1;
            started = 1'b1;
         end
         @(negedge CLK);
         if (In_Valid && In_Ready) p++;
      end
      if (p < NPX) check_eq("frame_timeout", p, NPX);
      @(posedge CLK); #1;
      In_Valid = 1'b0; Stall = 1'b0; Start = 1'b0;
   endtask

   task automatic end_frame();
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      check_eq("win_count", wq_r.size(), 32'd6);
      check_eq("fd_count", fd_cnt, 32'd1);
      check_eq("en_count", en_cnt, NPX);
      for (int i = 0; i < 6; i++) begin
         if (i < wq_r.size()) begin
            check_eq($sformatf("win_row%0d", i), wq_r[i], exp_r[i]);
            check_eq($sformatf("win_col%0d", i), wq_c[i], exp_c[i]);
         end
      end
   endtask

   initial begin
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check_eq("rst_ready", {31'd0, In_Ready}, 32'd0);
      check_eq("rst_en", {31'd0, Fifo_Enable}, 32'd0);
      check_eq("rst_din", {24'd0, Fifo_DataIn}, 32'd0);
      check_eq("rst_wv", {31'd0, Win_Valid}, 32'd0);
      check_eq("rst_wrow", {29'd0, Win_Row}, 32'd0);
      check_eq("rst_wcol", {29'd0, Win_Col}, 32'd0);
      check_eq("rst_busy", {31'd0, Busy}, 32'd0);
      check_eq("rst_fd", {31'd0, Frame_Done}, 32'd0);
      mon_en = 1'b1;

      // Basic contiguous frame.
      do_start();
      run_frame(1'b0, -1, -1, -1);
      end_frame();

      // Bubbles plus a 3-cycle stall in row 2.
      do_start();
      run_frame(1'b1, 11, -1, -1);
      end_frame();

      // Start pulse mid-frame must be ignored.
      do_start();
      run_frame(1'b0, -1, 7, -1);
      end_frame();

      // Reset at pixel 14, idle checks, then a fresh frame.
      do_start();
      run_frame(1'b0, -1, -1, 14);
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         RST = 1'b0; In_Valid = 1'b1; In_Data = 8'h5a;
         @(negedge CLK);
         check_eq("idle_ready", {31'd0, In_Ready}, 32'd0);
         check_eq("idle_en", {31'd0, Fifo_Enable}, 32'd0);
         check_eq("idle_wv", {31'd0, Win_Valid}, 32'd0);
         check_eq("idle_busy", {31'd0, Busy}, 32'd0);
      end
      do_start();
      run_frame(1'b1, -1, -1, -1);
      end_frame();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
